cnu_minsum_array: RTL and testbench

//  Check-node stage fed directly by the pi_2 shuffle. It takes 36 variable-to-check messages,

---
 rtl/cnu_minsum_array.sv | 122 ++++++++++++
 tb/tb_cnu_minsum_array.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnu_minsum_array.sv
// Offset min-sum check-node array: captures a block of NUM_GROUPS x GROUP_SIZE
// messages, evaluates one check node per cycle and presents the full result block.
module cnu_minsum_array #(
    parameter int DATA_WIDTH = 6,
    parameter int GROUP_SIZE = 6,
    parameter int NUM_GROUPS = 6,
    parameter int OFFSET     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in  [0:GROUP_SIZE*NUM_GROUPS-1],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out [0:GROUP_SIZE*NUM_GROUPS-1]
);
    // Handshake: a block transfers on any rising edge where valid and ready are both high;
    // out_valid and data_out hold steady until out_ready is seen, in_ready is high only in IDLE.

    localparam int N  = GROUP_SIZE * NUM_GROUPS;
    localparam int MW = DATA_WIDTH - 1;
    localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int IW = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
    localparam logic [MW-1:0] OFF  = MW'(OFFSET);
    localparam logic [GW-1:0] LAST = GW'(NUM_GROUPS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state;
    logic [GW-1:0]         grp;
    logic [DATA_WIDTH-1:0] in_buf [0:N-1];

    logic [MW-1:0]         mag    [0:GROUP_SIZE-1];
    logic                  sgn    [0:GROUP_SIZE-1];
    logic [DATA_WIDTH-1:0] res    [0:GROUP_SIZE-1];
    logic [MW-1:0]         min1;
    logic [MW-1:0]         min2;
    logic [MW-1:0]         sel;
    logic [IW-1:0]         idx1;
    logic                  s_all;

    // Single check node for the group currently addressed by grp.
    always_comb begin
        min1  = '1;
        min2  = '1;
        sel   = '0;
        idx1  = '0;
        s_all = 1'b0;
        for (int j = 0; j < GROUP_SIZE; j++) begin
            mag[j] = in_buf[int'(grp) * GROUP_SIZE + j][MW-1:0];
            sgn[j] = in_buf[int'(grp) * GROUP_SIZE + j][MW];
            res[j] = '0;
        end
        min1 = mag[0];
        for (int j = 1; j < GROUP_SIZE; j++) begin
            if (mag[j] < min1) begin
                min1 = mag[j];
                idx1 = IW'(j);
            end
        end
        // Second minimum excludes only the winning position, so a tie yields min2 == min1.
        for (int j = 0; j < GROUP_SIZE; j++) begin
            if (IW'(j) != idx1 && mag[j] < min2) begin
                min2 = mag[j];
            end
            s_all = s_all ^ sgn[j];
        end
        for (int j = 0; j < GROUP_SIZE; j++) begin
            sel    = (IW'(j) == idx1) ? min2 : min1;
            res[j] = {s_all ^ sgn[j], (sel > OFF) ? (sel - OFF) : {MW{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grp       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                in_buf[i]   <= '0;
                data_out[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_buf   <= data_in;
                        grp      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    for (int j = 0; j < GROUP_SIZE; j++) begin
                        data_out[int'(grp) * GROUP_SIZE + j] <= res[j];
                    end
                    if (grp == LAST) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        grp <= grp + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnu_minsum_array.sv
// Bench for cnu_minsum_array: directed corner blocks plus randomized blocks checked
// against a min-over-other-edges reference model.
module tb_cnu_minsum_array;

    typedef logic [5:0] blk_t [0:35];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic out_valid;
    logic out_ready = 1'b0;
    blk_t data_in;
    blk_t data_out;

    int checks = 0;
    int passes = 0;

    cnu_minsum_array dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Each output edge gets the smallest magnitude among the other edges of its check
    // node minus the offset (floored at 0), and the XOR of the other edges' signs.
    function automatic blk_t model(input blk_t b);
        blk_t r;
        int m;
        int s;
        for (int g = 0; g < 6; g++) begin
            for (int j = 0; j < 6; j++) begin
                m = 31;
                s = 0;
                for (int k = 0; k < 6; k++) begin
                    if (k != j) begin
                        if (int'(b[6*g+k][4:0]) < m) m = int'(b[6*g+k][4:0]);
                        s = s ^ int'(b[6*g+k][5]);
                    end
                end
                m = (m > 1) ? m - 1 : 0;
                r[6*g+j] = {s[0], m[4:0]};
            end
        end
        return r;
    endfunction

    function automatic blk_t rand_block();
        blk_t b;
        for (int i = 0; i < 36; i++) begin
            b[i][5]   = 1'($urandom_range(0, 1));
            b[i][4:0] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                     : 5'($urandom_range(0, 6));
        end
        return b;
    endfunction

    // Presents b, waits (bounded) for acceptance, then counts edges until out_valid.
    task automatic send_block(input blk_t b, output int lat);
        int n;
        data_in  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        lat = out_valid ? n : -1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        data_in  = rand_block();
        repeat (3) step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_flags: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        else passes++;
        for (int i = 0; i < 36; i++) begin
            checks++;
            if (data_out[i] !== 6'h00)
                $display("FAIL reset_data[%0d]: got %h required 00", i, data_out[i]);
            else passes++;
        end
        repeat (8) step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_nocapture: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        else passes++;
    endtask

    task automatic test_basic();
        blk_t b;
        blk_t e;
        blk_t k;
        int lat;
        for (int i = 0; i < 36; i++) b[i] = 6'h1F;
        b[0] = 6'h03; b[1] = 6'h07; b[2] = 6'h22; b[3] = 6'h09; b[4] = 6'h05; b[5] = 6'h04;
        for (int i = 0; i < 36; i++) k[i] = 6'h1E;
        k[0] = 6'h21; k[1] = 6'h21; k[2] = 6'h02; k[3] = 6'h21; k[4] = 6'h21; k[5] = 6'h21;
        e = model(b);
        out_ready = 1'b1;
        send_block(b, lat);
        checks++;
        if (lat !== 6) $display("FAIL basic_latency: got %0d required 6", lat);
        else passes++;
        for (int i = 0; i < 36; i++) begin
            checks++;
            if (data_out[i] !== k[i] || data_out[i] !== e[i])
                $display("FAIL basic_data[%0d]: got %h required %h", i, data_out[i], k[i]);
            else passes++;
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL basic_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        else passes++;
    endtask

    task automatic test_tie();
        blk_t b;
        blk_t e;
        int lat;
        b = rand_block();
        b[6] = 6'h04; b[7] = 6'h04; b[8] = 6'h08; b[9] = 6'h08; b[10] = 6'h08; b[11] = 6'h08;
        e = model(b);
        out_ready = 1'b1;
        send_block(b, lat);
        checks++;
        if (lat !== 6) $display("FAIL tie_latency: got %0d required 6", lat);
        else passes++;
        for (int i = 6; i < 12; i++) begin
            checks++;
            if (data_out[i] !== 6'h03)
                $display("FAIL tie_group[%0d]: got %h required 03", i, data_out[i]);
            else passes++;
        end
        for (int i = 0; i < 36; i++) begin
            checks++;
            if (data_out[i] !== e[i])
                $display("FAIL tie_data[%0d]: got %h required %h", i, data_out[i], e[i]);
            else passes++;
        end
        step();
    endtask

    task automatic test_backpressure();
        blk_t b;
        blk_t e;
        int lat;
        int bad;
        b = rand_block();
        e = model(b);
        out_ready = 1'b0;
        send_block(b, lat);
        checks++;
        if (lat !== 6) $display("FAIL bp_latency: got %0d required 6", lat);
        else passes++;
        in_valid = 1'b1;
        data_in  = rand_block();
        for (int c = 0; c < 10; c++) begin
            bad = 0;
            for (int i = 0; i < 36; i++) if (data_out[i] !== e[i]) bad++;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || bad != 0)
                $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b bad_words=%0d required 1/0/0",
                         c, out_valid, in_ready, bad);
            else passes++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        else passes++;
        step();
        bad = 0;
        for (int i = 0; i < 36; i++) if (data_out[i] !== e[i]) bad++;
        checks++;
        if (out_valid !== 1'b0 || bad != 0)
            $display("FAIL bp_idle_hold: out_valid=%b bad_words=%0d required 0/0", out_valid, bad);
        else passes++;
    endtask

    task automatic test_saturation();
        blk_t b;
        blk_t e;
        blk_t k;
        int lat;
        b = rand_block();
        b[30] = 6'h20; b[31] = 6'h00; b[32] = 6'h01; b[33] = 6'h21; b[34] = 6'h01; b[35] = 6'h01;
        k[30] = 6'h20; k[31] = 6'h00; k[32] = 6'h00; k[33] = 6'h20; k[34] = 6'h00; k[35] = 6'h00;
        e = model(b);
        out_ready = 1'b1;
        send_block(b, lat);
        checks++;
        if (lat !== 6) $display("FAIL sat_latency: got %0d required 6", lat);
        else passes++;
        for (int i = 0; i < 36; i++) begin
            checks++;
            if (data_out[i] !== e[i] || (i >= 30 && data_out[i] !== k[i]))
                $display("FAIL sat_data[%0d]: got %h required %h", i, data_out[i], e[i]);
            else passes++;
        end
        step();
    endtask

    task automatic test_reset_busy();
        blk_t b;
        blk_t e;
        int lat;
        int bad;
        out_ready = 1'b1;
        data_in   = rand_block();
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 36; i++) if (data_out[i] !== 6'h00) bad++;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || bad != 0)
            $display("FAIL busy_reset: out_valid=%b in_ready=%b nonzero_words=%0d required 0/1/0",
                     out_valid, in_ready, bad);
        else passes++;
        b = rand_block();
        e = model(b);
        send_block(b, lat);
        checks++;
        if (lat !== 6) $display("FAIL busy_reset_latency: got %0d required 6", lat);
        else passes++;
        for (int i = 0; i < 36; i++) begin
            checks++;
            if (data_out[i] !== e[i])
                $display("FAIL busy_reset_data[%0d]: got %h required %h", i, data_out[i], e[i]);
            else passes++;
        end
        step();
    endtask

    task automatic test_back_to_back();
        blk_t b;
        blk_t e;
        int lat;
        int bad;
        for (int n = 0; n < 25; n++) begin
            b = rand_block();
            e = model(b);
            out_ready = 1'b0;
            send_block(b, lat);
            checks++;
            if (lat !== 6) $display("FAIL rand_latency blk %0d: got %0d required 6", n, lat);
            else passes++;
            repeat ($urandom_range(0, 3)) step();
            bad = 0;
            for (int i = 0; i < 36; i++) begin
                if (data_out[i] !== e[i]) begin
                    if (bad == 0)
                        $display("FAIL rand_data blk %0d [%0d]: got %h required %h",
                                 n, i, data_out[i], e[i]);
                    bad++;
                end
            end
            checks++;
            if (bad == 0) passes++;
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_saturation();
        test_reset_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
